// File: rtl/isp_pixel_capture.sv
// rtl/isp_pixel_capture.sv - camera pixel pair packer with output FIFO, line/frame counters
// Optional overflow detection and interrupt: define ISP_CAPTURE_OVF_EN.
module isp_pixel_capture #(
   parameter int BITS       = 16,
   parameter int PIX_W      = 8,
   parameter int FIFO_DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             cap_en,
   input  logic [PIX_W-1:0] pix_data,
   input  logic             pix_href,
   input  logic             pix_vsync,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [BITS-1:0]  out_data,
   output logic             out_sof,
   output logic             out_eol,
   output logic [15:0]      line_count,
   output logic [15:0]      frame_count,
   output logic             frame_done,
   output logic             ovf,
   output logic             irq_ovf
);

   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

   localparam logic [1:0] ST_IDLE     = 2'd0;
   localparam logic [1:0] ST_WAIT_SOF = 2'd1;
   localparam logic [1:0] ST_ACTIVE   = 2'd2;

   logic [1:0]       state;
   logic             vsync_q;
   logic             href_q;
   logic [PIX_W-1:0] low_q;
   logic             low_vld;
   logic [BITS-1:0]  stg_data;
   logic             stg_vld;
   logic             sof_pend;

   logic [BITS-1:0]  mem_data [FIFO_DEPTH];
   logic             mem_sof  [FIFO_DEPTH];
   logic             mem_eol  [FIFO_DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;

   logic             active;
   logic             pix_take;
   logic             line_end;
   logic             frame_end;
   logic             sof_edge;
   logic             push;
   logic [BITS-1:0]  push_data;
   logic             push_eol;
   logic             pop;
   logic             full;
   logic             wr_ok;

   assign active    = (state == ST_ACTIVE);
   assign pix_take  = active & pix_href & ~pix_vsync;
   assign line_end  = active & href_q & ~pix_href;
   assign frame_end = active & ~vsync_q & pix_vsync;
   assign sof_edge  = cap_en & (state == ST_WAIT_SOF) & vsync_q & ~pix_vsync;

   // The staged pair is released when the next line pixel proves the line continues,
   // or closed with eol at the line/frame end; at most one push per cycle results.
   always_comb begin
      push      = 1'b0;
      push_data = '0;
      push_eol  = 1'b0;
      if (cap_en) begin
         if (pix_take && !low_vld && stg_vld) begin
            push      = 1'b1;
            push_data = stg_data;
         end else if ((line_end || frame_end) && low_vld) begin
            push      = 1'b1;
            push_data = {{PIX_W{1'b0}}, low_q};
            push_eol  = 1'b1;
         end else if ((line_end || frame_end) && stg_vld) begin
            push      = 1'b1;
            push_data = stg_data;
            push_eol  = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= ST_IDLE;
         vsync_q     <= 1'b0;
         href_q      <= 1'b0;
         low_q       <= '0;
         low_vld     <= 1'b0;
         stg_data    <= '0;
         stg_vld     <= 1'b0;
         sof_pend    <= 1'b0;
         line_count  <= '0;
         frame_count <= '0;
         frame_done  <= 1'b0;
      end else begin
         vsync_q    <= pix_vsync;
         href_q     <= pix_href;
         frame_done <= 1'b0;
         if (!cap_en) begin
            state    <= ST_IDLE;
            low_vld  <= 1'b0;
            stg_vld  <= 1'b0;
            sof_pend <= 1'b0;
         end else begin
            case (state)
               ST_IDLE: state <= ST_WAIT_SOF;
               ST_WAIT_SOF: begin
                  if (sof_edge) begin
                     state      <= ST_ACTIVE;
                     line_count <= '0;
                     low_vld    <= 1'b0;
                     stg_vld    <= 1'b0;
                     sof_pend   <= 1'b1;
                  end
               end
               ST_ACTIVE: begin
                  if (frame_end) begin
                     state       <= ST_WAIT_SOF;
                     frame_done  <= 1'b1;
                     frame_count <= frame_count + 16'd1;
                     low_vld     <= 1'b0;
                     stg_vld     <= 1'b0;
                  end
                  if (line_end) begin
                     line_count <= line_count + 16'd1;
                     low_vld    <= 1'b0;
                     stg_vld    <= 1'b0;
                  end
                  if (pix_take) begin
                     if (!low_vld) begin
                        low_q   <= pix_data;
                        low_vld <= 1'b1;
                        stg_vld <= 1'b0;
                     end else begin
                        stg_data <= {pix_data, low_q};
                        stg_vld  <= 1'b1;
                        low_vld  <= 1'b0;
                     end
                  end
                  if (push) sof_pend <= 1'b0;
               end
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

   assign out_valid = (count != '0);
   assign pop       = out_valid & out_ready;
   assign full      = (count == (AW+1)'(FIFO_DEPTH));
   assign wr_ok     = push & (~full | pop);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (!cap_en) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
         if (pop) rd_ptr <= rd_ptr + AW'(1);
         count <= count + (AW+1)'(wr_ok) - (AW+1)'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (wr_ok) begin
         mem_data[wr_ptr] <= push_data;
         mem_sof[wr_ptr]  <= sof_pend;
         mem_eol[wr_ptr]  <= push_eol;
      end
   end

   // Head fields read as zero while empty so reset and flush present a clean bus.
   assign out_data = out_valid ? mem_data[rd_ptr] : '0;
   assign out_sof  = out_valid ? mem_sof[rd_ptr]  : 1'b0;
   assign out_eol  = out_valid ? mem_eol[rd_ptr]  : 1'b0;

`ifdef ISP_CAPTURE_OVF_EN
   logic drop;
   logic ovf_q;
   logic irq_q;
   logic ovf_frame;

   assign drop = push & full & ~pop;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ovf_q     <= 1'b0;
         irq_q     <= 1'b0;
         ovf_frame <= 1'b0;
      end else if (!cap_en) begin
         ovf_q     <= 1'b0;
         irq_q     <= 1'b0;
         ovf_frame <= 1'b0;
      end else begin
         irq_q <= drop & ~ovf_frame;
         if (drop) begin
            ovf_q     <= 1'b1;
            ovf_frame <= 1'b1;
         end else if (sof_edge) begin
            ovf_frame <= 1'b0;
         end
      end
   end

   assign ovf     = ovf_q;
   assign irq_ovf = irq_q;
`else
   assign ovf     = 1'b0;
   assign irq_ovf = 1'b0;
`endif

endmodule

// File: tb/tb_isp_pixel_capture.sv
// tb/tb_isp_pixel_capture.sv - directed and randomized bench for isp_pixel_capture
// Overflow expectations follow ISP_CAPTURE_OVF_EN.
module tb_isp_pixel_capture;

   localparam int FIFO_DEPTH = 4;
`ifdef ISP_CAPTURE_OVF_EN
   localparam logic EXP_OVF = 1'b1;
   localparam int   EXP_IRQ = 1;
`else
   localparam logic EXP_OVF = 1'b0;
   localparam int   EXP_IRQ = 0;
`endif

   logic        clk = 1'b0;
   logic        reset_n;
   logic        cap_en;
   logic [7:0]  pix_data;
   logic        pix_href;
   logic        pix_vsync;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_data;
   logic        out_sof;
   logic        out_eol;
   logic [15:0] line_count;
   logic [15:0] frame_count;
   logic        frame_done;
   logic        ovf;
   logic        irq_ovf;

   int errors = 0;
   int checks = 0;
   int fd_cnt = 0;
   int irq_cnt = 0;
   int exp_lines = 0;
   int exp_frames = 0;
   logic        exp_sof_next;
   logic        rand_ready;
   logic        prev_ready;
   logic [17:0] got[$];
   logic [17:0] exp_q[$];
   logic [7:0]  line_px[16];
   int          line_len;

   isp_pixel_capture #(.BITS(16), .PIX_W(8), .FIFO_DEPTH(FIFO_DEPTH)) dut (
      .clk(clk), .reset_n(reset_n), .cap_en(cap_en), .pix_data(pix_data),
      .pix_href(pix_href), .pix_vsync(pix_vsync), .out_valid(out_valid),
      .out_ready(out_ready), .out_data(out_data), .out_sof(out_sof),
      .out_eol(out_eol), .line_count(line_count), .frame_count(frame_count),
      .frame_done(frame_done), .ovf(ovf), .irq_ovf(irq_ovf)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (reset_n) begin
         if (out_valid && out_ready) got.push_back({out_sof, out_eol, out_data});
         if (frame_done) fd_cnt++;
         if (irq_ovf) irq_cnt++;
      end
   end

   initial begin
      #3000000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      if (rand_ready) begin
         out_ready  = !prev_ready ? 1'b1 : ($urandom_range(0, 2) != 0);
         prev_ready = out_ready;
      end
   endtask

   task automatic start_frame();
      pix_href  = 1'b0;
      pix_vsync = 1'b1;
      step();
      step();
      pix_vsync = 1'b0;
      step();
      exp_sof_next = 1'b1;
      exp_lines    = 0;
   endtask

   task automatic end_frame();
      pix_vsync = 1'b1;
      step();
      step();
      exp_frames++;
   endtask

   // Reference: pixels pair up low-first, an odd tail is zero-padded, last word of a line has eol.
   task automatic send_line();
      logic [15:0] w;
      logic        eol_b;
      for (int i = 0; i < line_len; i++) begin
         pix_href = 1'b1;
         pix_data = line_px[i];
         step();
      end
      pix_href = 1'b0;
      pix_data = 8'h00;
      step();
      step();
      step();
      for (int i = 0; i < line_len; i += 2) begin
         w     = (i + 1 < line_len) ? {line_px[i+1], line_px[i]} : {8'h00, line_px[i]};
         eol_b = (i + 2 >= line_len);
         exp_q.push_back({exp_sof_next, eol_b, w});
         exp_sof_next = 1'b0;
      end
      exp_lines++;
   endtask

   task automatic rand_line();
      line_len = $urandom_range(1, 9);
      for (int i = 0; i < line_len; i++) line_px[i] = 8'($urandom);
      send_line();
   endtask

   task automatic drain_compare(input string tag);
      int n = 0;
      while (got.size() < exp_q.size() && n < 400) begin
         step();
         n++;
      end
      step();
      step();
      check($sformatf("%s_count", tag), 32'(got.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < got.size(); i++)
         check($sformatf("%s_word%0d", tag, i), 32'(got[i]), 32'(exp_q[i]));
   endtask

   task automatic clear_q();
      got.delete();
      exp_q.delete();
   endtask

   task automatic rand_frame(input string tag);
      int nl;
      start_frame();
      check($sformatf("%s_lc_entry", tag), 32'(line_count), 32'd0);
      nl = $urandom_range(2, 4);
      for (int l = 0; l < nl; l++) rand_line();
      end_frame();
      drain_compare(tag);
      clear_q();
      check($sformatf("%s_line_count", tag), 32'(line_count), 32'(exp_lines));
      check($sformatf("%s_frame_count", tag), 32'(frame_count), 32'(16'(exp_frames)));
      check($sformatf("%s_frame_done", tag), 32'(fd_cnt), 32'(exp_frames));
   endtask

   initial begin
      logic [15:0] lc_hold;
      logic [15:0] fc_hold;
      reset_n = 1'b0; cap_en = 1'b0; pix_data = 8'h00; pix_href = 1'b0; pix_vsync = 1'b0;
      out_ready = 1'b1; rand_ready = 1'b0; prev_ready = 1'b1; exp_sof_next = 1'b0;
      repeat (3) step();
      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_data", 32'(out_data), 32'd0);
      check("rst_flags", 32'({out_sof, out_eol, frame_done, ovf, irq_ovf}), 32'd0);
      check("rst_line_count", 32'(line_count), 32'd0);
      check("rst_frame_count", 32'(frame_count), 32'd0);
      reset_n = 1'b1;
      cap_en  = 1'b1;
      step();

      // Directed frame: even line then odd line
      start_frame();
      line_len = 4;
      line_px[0] = 8'h11; line_px[1] = 8'h22; line_px[2] = 8'h33; line_px[3] = 8'h44;
      send_line();
      check("even_line_count", 32'(line_count), 32'd1);
      line_len = 3;
      line_px[0] = 8'hA1; line_px[1] = 8'hB2; line_px[2] = 8'hC3;
      send_line();
      end_frame();
      drain_compare("dir");
      if (got.size() >= 4) begin
         check("even_w0", 32'(got[0]), 32'({1'b1, 1'b0, 16'h2211}));
         check("even_w1", 32'(got[1]), 32'({1'b0, 1'b1, 16'h4433}));
         check("odd_w0", 32'(got[2]), 32'({1'b0, 1'b0, 16'hB2A1}));
         check("odd_w1", 32'(got[3]), 32'({1'b0, 1'b1, 16'h00C3}));
      end
      clear_q();
      check("fe_line_count", 32'(line_count), 32'd2);
      check("fe_frame_count", 32'(frame_count), 32'd1);
      check("fe_frame_done_cycles", 32'(fd_cnt), 32'd1);

      // Randomized frames under random backpressure
      rand_ready = 1'b1;
      rand_frame("rnd1");
      rand_frame("rnd2");
      rand_ready = 1'b0;
      out_ready  = 1'b1;

      // Overflow: 12 pixels into a stalled 4-deep FIFO
      out_ready = 1'b0;
      start_frame();
      line_len = 12;
      for (int i = 0; i < 12; i++) line_px[i] = 8'(i + 1);
      send_line();
      while (exp_q.size() > FIFO_DEPTH) void'(exp_q.pop_back());
      step();
      check("ovf_valid", 32'(out_valid), 32'd1);
      check("ovf_flag", 32'(ovf), 32'(EXP_OVF));
      check("ovf_irq_pulses", 32'(irq_cnt), 32'(EXP_IRQ));
      out_ready = 1'b1;
      drain_compare("ovf");
      if (got.size() >= 1) check("ovf_first_data", 32'(got[0][15:0]), 32'h0201);
      clear_q();
      end_frame();
      check("ovf_frame_count", 32'(frame_count), 32'(16'(exp_frames)));

      rand_ready = 1'b1;
      rand_frame("rnd3");
      rand_ready = 1'b0;

      // Abort mid-line with two words queued
      out_ready = 1'b0;
      start_frame();
      for (int i = 0; i < 6; i++) begin
         pix_href = 1'b1;
         pix_data = 8'($urandom);
         step();
      end
      check("abort_queued", 32'(out_valid), 32'd1);
      lc_hold = line_count;
      fc_hold = frame_count;
      cap_en  = 1'b0;
      step();
      check("abort_valid", 32'(out_valid), 32'd0);
      check("abort_line_count", 32'(line_count), 32'(lc_hold));
      check("abort_frame_count", 32'(frame_count), 32'(fc_hold));
      check("abort_ovf", 32'(ovf), 32'd0);
      pix_href  = 1'b0;
      cap_en    = 1'b1;
      out_ready = 1'b1;
      step();
      rand_line();
      exp_q.delete();
      check("abort_no_capture", 32'(got.size()), 32'd0);
      start_frame();
      rand_line();
      rand_line();
      end_frame();
      drain_compare("post_abort");
      if (got.size() >= 1) check("post_abort_sof", 32'(got[0][17]), 32'd1);
      clear_q();
      check("post_abort_frame_done", 32'(fd_cnt), 32'(exp_frames));

      // Asynchronous reset mid-line with the FIFO non-empty
      out_ready = 1'b0;
      start_frame();
      for (int i = 0; i < 4; i++) begin
         pix_href = 1'b1;
         pix_data = 8'(8'h50 + i);
         step();
      end
      check("prerst_valid", 32'(out_valid), 32'd1);
      #2;
      reset_n = 1'b0;
      #1;
      check("arst_valid", 32'(out_valid), 32'd0);
      check("arst_data", 32'(out_data), 32'd0);
      check("arst_flags", 32'({out_sof, out_eol, frame_done, ovf, irq_ovf}), 32'd0);
      check("arst_line_count", 32'(line_count), 32'd0);
      check("arst_frame_count", 32'(frame_count), 32'd0);
      step();
      reset_n   = 1'b1;
      pix_href  = 1'b0;
      out_ready = 1'b1;
      clear_q();
      step();
      check("rel_valid", 32'(out_valid), 32'd0);
      rand_line();
      exp_q.delete();
      check("rel_idle_no_capture", 32'(got.size()), 32'd0);
      check("rel_idle_valid", 32'(out_valid), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
